// File: rtl/ps2_key_tracker_if.sv
// Scan-code byte link from the PS/2 byte receiver to ps2_key_tracker.
// Handshake: rx_valid is a one-cycle strobe and rx_data is meaningful only in
// that cycle. There is no ready; the consumer must accept every strobed byte.
interface ps2_key_tracker_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: turns PS/2 set-2 scan codes into held-key flags (A, D, W,
// Space), a last-pressed-wins left/right direction and a one-cycle change strobe.
// A prefix (E0/F0) left pending for TIMEOUT_CYCLES idle cycles is abandoned.
// Optional macro ARROW_KEYS_EN: extended left/right arrows (E0 6B / E0 74)
// alias onto the A / D flags. Without it every extended code is ignored.
// fsm_state exposes the prefix state (0 IDLE, 1 EXT, 2 BRK, 3 EXT_BRK).
module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 400000,
  parameter int CNT_W          = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  ps2_key_tracker_if.slave        rx,
  output logic                    a_pressed,
  output logic                    d_pressed,
  output logic                    w_pressed,
  output logic                    space_pressed,
  output logic [1:0]              move_dir,
  output logic                    key_event,
  output logic [1:0]              fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic       is_e0, is_f0, is_ext;
  logic       do_make, do_rel;
  logic       hit_a, hit_d, hit_w, hit_sp;
  logic       a_next, d_next, w_next, sp_next;
  logic [1:0] dir_next;
  logic       changed;

  assign fsm_state = state;

  // Decode the strobed byte against the current prefix state into a key action.
  always_comb begin
    is_e0   = (rx.rx_data == 8'hE0);
    is_f0   = (rx.rx_data == 8'hF0);
    is_ext  = (state == EXT) || (state == EXT_BRK);
    do_make = 1'b0;
    do_rel  = 1'b0;
    hit_a   = 1'b0;
    hit_d   = 1'b0;
    hit_w   = 1'b0;
    hit_sp  = 1'b0;

    if (rx.rx_valid && !is_e0 && !is_f0) begin
      do_make = (state == IDLE) || (state == EXT);
      do_rel  = (state == BRK)  || (state == EXT_BRK);
    end

    if (!is_ext) begin
      hit_a  = (rx.rx_data == 8'h1C);
      hit_d  = (rx.rx_data == 8'h23);
      hit_w  = (rx.rx_data == 8'h1D);
      hit_sp = (rx.rx_data == 8'h29);
    end else begin
`ifdef ARROW_KEYS_EN
      hit_a = (rx.rx_data == 8'h6B);
      hit_d = (rx.rx_data == 8'h74);
`else
      hit_a = 1'b0;
      hit_d = 1'b0;
`endif
    end
  end

  // Next flag values and direction; repeats and releases of unheld keys fall out as no-ops.
  always_comb begin
    a_next   = a_pressed;
    d_next   = d_pressed;
    w_next   = w_pressed;
    sp_next  = space_pressed;
    dir_next = move_dir;

    if (do_make) begin
      if (hit_a)  a_next  = 1'b1;
      if (hit_d)  d_next  = 1'b1;
      if (hit_w)  w_next  = 1'b1;
      if (hit_sp) sp_next = 1'b1;
      if (hit_a && !a_pressed) dir_next = 2'b01;
      if (hit_d && !d_pressed) dir_next = 2'b10;
    end

    if (do_rel) begin
      if (hit_a)  a_next  = 1'b0;
      if (hit_d)  d_next  = 1'b0;
      if (hit_w)  w_next  = 1'b0;
      if (hit_sp) sp_next = 1'b0;
      if (hit_a && a_pressed) dir_next = d_pressed ? 2'b10 : 2'b00;
      if (hit_d && d_pressed) dir_next = a_pressed ? 2'b01 : 2'b00;
    end

    changed = (a_next != a_pressed) || (d_next != d_pressed) ||
              (w_next != w_pressed) || (sp_next != space_pressed);
  end

  // Prefix FSM, timeout counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      a_pressed     <= 1'b0;
      d_pressed     <= 1'b0;
      w_pressed     <= 1'b0;
      space_pressed <= 1'b0;
      move_dir      <= 2'b00;
      key_event     <= 1'b0;
    end else begin
      a_pressed     <= a_next;
      d_pressed     <= d_next;
      w_pressed     <= w_next;
      space_pressed <= sp_next;
      move_dir      <= dir_next;
      key_event     <= changed;

      if (rx.rx_valid) begin
        // A byte always wins over a timeout landing in the same cycle.
        cnt <= '0;
        unique case (state)
          IDLE:    state <= is_e0 ? EXT : (is_f0 ? BRK : IDLE);
          EXT:     state <= is_f0 ? EXT_BRK : (is_e0 ? EXT : IDLE);
          BRK:     state <= is_e0 ? EXT : (is_f0 ? BRK : IDLE);
          EXT_BRK: state <= (is_e0 || is_f0) ? EXT_BRK : IDLE;
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        cnt <= '0;
      end else if (cnt == CNT_LIMIT) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Converts the PS/2 scan-code byte stream (set 2) from the PS/2 byte receiver into held-key flags and a movement direction for the player controller (draw_player_ctl).
- Sits between the PS/2 receiver and draw_player_ctl, in the clk_40 domain.
- Tracks make, break (F0) and extended (E0) prefixes with a state machine.
- Provides a prefix-timeout resync and one-cycle change strobes.

Parameters:
- TIMEOUT_CYCLES, 400000, clk cycles without a byte before a pending prefix is abandoned (10 ms at 40 MHz).
- CNT_W, 19, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock (clk_40)
- rst  in  1  asynchronous, active-low reset
- rx_data  in  8  received scan-code byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
- a_pressed  out  1  A key (0x1C) held
- d_pressed  out  1  D key (0x23) held
- w_pressed  out  1  W key (0x1D) held
- space_pressed  out  1  Space (0x29) held
- move_dir  out  2  00 idle, 01 left, 10 right; 11 is never driven
- key_event  out  1  one-cycle pulse when any *_pressed flag changes

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM in IDLE, timeout counter 0.
- All outputs are registered. An update caused by a byte at cycle N is visible at cycle N+1. key_event pulses in cycle N+1 only.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions occur only on rx_valid=1.
  - IDLE: E0 -> EXT; F0 -> BRK; other byte -> make(byte), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte -> ext_make(byte) -> IDLE.
  - BRK: E0 -> EXT (malformed, no key change); F0 -> stay BRK; other byte -> release(byte) -> IDLE.
  - EXT_BRK: E0/F0 -> stay EXT_BRK; other byte -> ext_release(byte) -> IDLE.
- make/release of a tracked code sets/clears the matching flag. Untracked codes have no effect.
- ext_make/ext_release with the optional feature disabled: no effect.
- Typematic repeat (make of an already-held key): no flag change, no key_event, move_dir unchanged.
- Release of a key that is not held: no change, no key_event.
- move_dir, last-pressed-wins between A and D:
  - A make (new) -> 01; D make (new) -> 10.
  - A release while D held -> 10; D release while A held -> 01.
  - Release with the other key not held -> 00.
  - W and Space never affect move_dir.
- Timeout:
  - In any non-IDLE state, the counter increments each cycle with rx_valid=0.
  - On reaching TIMEOUT_CYCLES-1, FSM -> IDLE with no key change, and the counter clears.
  - The counter clears on every rx_valid and whenever the FSM is in IDLE.
  - If a byte arrives in the same cycle the counter hits its limit, the byte wins and is processed in the current state.
- key_event asserts if at least one flag changed in that update. Multi-flag changes are impossible (one byte per update).
- Asynchronous reset mid-sequence (e.g. after F0) discards the prefix. The next byte is decoded from IDLE.

Optional Feature:
- Macro ARROW_KEYS_EN.
- Defined:
  - ext_make/ext_release of 0x6B (left arrow) behave as A; of 0x74 (right arrow) behave as D.
  - Arrow and letter share the same flag: A make then E0 6B make is a repeat (no event), and either release clears it.
- Not defined: all extended codes are decoded by the FSM but ignored. E0 1C does not press A.

Test Plan:
- Reset then bytes 1C -> a_pressed=1, move_dir=01, key_event high exactly one cycle, one cycle after the rx_valid strobe.
- 1C, 23, F0 23 -> after 23: move_dir=10, d_pressed=1; after F0 23: d_pressed=0, a_pressed=1, move_dir=01. Then F0 1C -> all 0, move_dir=00.
- 1C repeated 5 times, then 29 -> single key_event for A; space_pressed=1; move_dir stays 01.
- F0, then no byte for TIMEOUT_CYCLES cycles, then 1C -> 1C treated as make: a_pressed=1. Without the timeout it would be a release of an unheld key.
- E0 6B then E0 F0 6B -> with ARROW_KEYS_EN: a_pressed 1 then 0, move_dir 01 then 00. Without it: no output change, no key_event.
- Assert rst low between F0 and 23 while d_pressed=1 -> outputs 0 immediately. Subsequent 23 -> d_pressed=1.
